// File: rtl/stack_pkg.sv
// Shared types and helpers for the stack controller.
// The pair FSM states are used only when STACK_PAIR_EN is defined.
package stack_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_HI = 2'd1,
        ST_POP_LO  = 2'd2
    } state_e;

    // Returns {full, empty} for an occupancy count.
    function automatic logic [1:0] cnt_flags(input int cnt, input int depth);
        return {cnt == depth, cnt == 0};
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one combinational read port.
// The array has no reset, so its contents survive a controller reset.
module stack_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_ctrl.sv
// Parametrised stack controller: occupancy, registered pop data, sticky errors.
// Define STACK_PAIR_EN to add the two-word push2/pop2 operations and busy.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              err_clr_i,
`ifdef STACK_PAIR_EN
    input  logic              push2_i,
    input  logic              pop2_i,
    input  logic [DATA_W-1:0] din_hi_i,
    output logic              busy_o,
`endif
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic [PTR_W:0]    count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_err_o,
    output logic              udf_err_o
);

    // The occupancy count doubles as the stack pointer: next free slot = count.
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dval_q, dval_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              ovf_ev, udf_ev, single_op;
    logic              we;
    logic [PTR_W-1:0]  waddr, top_addr;
    logic [DATA_W-1:0] wdata, rdata;

`ifdef STACK_PAIR_EN
    localparam logic [PTR_W:0] CNT_LIM2 = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] din_hi_q, din_hi_d;
    assign busy_o = (state_q != ST_IDLE);
`endif

    assign {full_o, empty_o} = cnt_flags(32'(count_q), DEPTH);
    assign top_addr = PTR_W'(count_q - 1'b1);

    stack_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (top_addr),
        .rdata_o (rdata)
    );

    always_comb begin
        count_d   = count_q;
        dout_d    = dout_q;
        dval_d    = 1'b0;
        ovf_ev    = 1'b0;
        udf_ev    = 1'b0;
        we        = 1'b0;
        waddr     = count_q[PTR_W-1:0];
        wdata     = din_i;
        single_op = 1'b1;
`ifdef STACK_PAIR_EN
        state_d   = state_q;
        din_hi_d  = din_hi_q;
        single_op = 1'b0;
        case (state_q)
            ST_PUSH_HI: begin
                we      = 1'b1;
                wdata   = din_hi_q;
                count_d = count_q + 1'b1;
                state_d = ST_IDLE;
            end
            ST_POP_LO: begin
                dout_d  = rdata;
                dval_d  = 1'b1;
                count_d = count_q - 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                if (push2_i) begin
                    if (count_q <= CNT_LIM2) begin
                        we       = 1'b1;
                        count_d  = count_q + 1'b1;
                        din_hi_d = din_hi_i;
                        state_d  = ST_PUSH_HI;
                    end else ovf_ev = 1'b1;
                end else if (pop2_i) begin
                    if (count_q >= CNT_TWO) begin
                        dout_d  = rdata;
                        dval_d  = 1'b1;
                        count_d = count_q - 1'b1;
                        state_d = ST_POP_LO;
                    end else udf_ev = 1'b1;
                end else single_op = 1'b1;
            end
        endcase
`endif
        if (single_op) begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (!full_o) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                    end else ovf_ev = 1'b1;
                end
                2'b01: begin
                    if (!empty_o) begin
                        dout_d  = rdata;
                        dval_d  = 1'b1;
                        count_d = count_q - 1'b1;
                    end else udf_ev = 1'b1;
                end
                2'b11: begin
                    // Replace-top reads the old word and overwrites it on the same edge.
                    we = 1'b1;
                    if (!empty_o) begin
                        dout_d = rdata;
                        dval_d = 1'b1;
                        waddr  = top_addr;
                    end else begin
                        count_d = count_q + 1'b1;
                        udf_ev  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // A new error event outranks a simultaneous clear.
        ovf_d = ovf_ev | (ovf_q & ~err_clr_i);
        udf_d = udf_ev | (udf_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            dout_q   <= '0;
            dval_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
`ifdef STACK_PAIR_EN
            state_q  <= ST_IDLE;
            din_hi_q <= '0;
`endif
        end else begin
            count_q  <= count_d;
            dout_q   <= dout_d;
            dval_q   <= dval_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
`ifdef STACK_PAIR_EN
            state_q  <= state_d;
            din_hi_q <= din_hi_d;
`endif
        end
    end

    assign count_o      = count_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dval_q;
    assign ovf_err_o    = ovf_q;
    assign udf_err_o    = udf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Table-driven bench for stack_ctrl (DATA_W=4, DEPTH=8) with a dout scoreboard.
// Pair-operation sequences are compiled in when STACK_PAIR_EN is defined.
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push, pop, err_clr;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dout_valid;
    logic [3:0] count;
    logic       full, empty, ovf_err, udf_err;
`ifdef STACK_PAIR_EN
    logic       push2, pop2, busy;
    logic [3:0] din_hi;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [3:0] sb [$];

    typedef struct {
        logic       push, pop, clr;
        logic [3:0] din;
        logic [3:0] cnt;
        logic       full, empty, ovf, udf, dval;
        logic [3:0] dout;
    } vec_t;

    vec_t tbl [$];

    stack_ctrl #(.DATA_W(4), .DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_i       (push),
        .pop_i        (pop),
        .din_i        (din),
        .err_clr_i    (err_clr),
`ifdef STACK_PAIR_EN
        .push2_i      (push2),
        .pop2_i       (pop2),
        .din_hi_i     (din_hi),
        .busy_o       (busy),
`endif
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .ovf_err_o    (ovf_err),
        .udf_err_o    (udf_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input logic pu, input logic po, input logic cl, input logic [3:0] di,
                               input logic [3:0] c, input logic fu, input logic em, input logic ov,
                               input logic ud, input logic dv, input logic [3:0] dq);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.din = di; v.cnt = c; v.full = fu;
        v.empty = em; v.ovf = ov; v.udf = ud; v.dval = dv; v.dout = dq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compares a valid pulse against the oldest scoreboard entry.
    task automatic check_dout();
        logic [3:0] e;
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dout_valid", 32'(dout_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("dout", 32'(dout), 32'(e));
            end
        end else if (sb.size() != 0) begin
            chk("missing_dout_valid", 32'(dout_valid), 32'(1));
            sb.delete();
        end
    endtask

    task automatic apply(input vec_t v);
        push = v.push; pop = v.pop; err_clr = v.clr; din = v.din;
        if (v.dval) sb.push_back(v.dout);
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        chk("count", 32'(count), 32'(v.cnt));
        chk("full", 32'(full), 32'(v.full));
        chk("empty", 32'(empty), 32'(v.empty));
        chk("ovf_err", 32'(ovf_err), 32'(v.ovf));
        chk("udf_err", 32'(udf_err), 32'(v.udf));
        chk("dout_valid", 32'(dout_valid), 32'(v.dval));
        check_dout();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;
`ifdef STACK_PAIR_EN
        push2 = 1'b0; pop2 = 1'b0; din_hi = '0;
`endif
        // LIFO order and one-cycle pop latency
        tbl.push_back(V(1,0,0,4'h3, 1,0,0,0,0,0,4'h0));
        tbl.push_back(V(1,0,0,4'hA, 2,0,0,0,0,0,4'h0));
        tbl.push_back(V(1,0,0,4'h5, 3,0,0,0,0,0,4'h0));
        tbl.push_back(V(0,1,0,4'h0, 2,0,0,0,0,1,4'h5));
        tbl.push_back(V(0,1,0,4'h0, 1,0,0,0,0,1,4'hA));
        tbl.push_back(V(0,1,0,4'h0, 0,0,1,0,0,1,4'h3));
        // underflow, error-beats-clear, then clear
        tbl.push_back(V(0,1,0,4'h0, 0,0,1,0,1,0,4'h0));
        tbl.push_back(V(0,1,1,4'h0, 0,0,1,0,1,0,4'h0));
        tbl.push_back(V(0,0,1,4'h0, 0,0,1,0,0,0,4'h0));
        // fill, overflow, replace-top while full, clear
        for (int i = 1; i <= 8; i++)
            tbl.push_back(V(1,0,0,4'(i), 4'(i),(i == 8),0,0,0,0,4'h0));
        tbl.push_back(V(1,0,0,4'hF, 8,1,0,1,0,0,4'h0));
        tbl.push_back(V(1,1,0,4'hE, 8,1,0,1,0,1,4'h8));
        tbl.push_back(V(0,0,1,4'h0, 8,1,0,0,0,0,4'h0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(V(0,1,0,4'h0, 4'(7-i),0,(i == 7),0,0,1,(i == 0) ? 4'hE : 4'(8-i)));
        // replace-top mid-stack, then push+pop on empty
        tbl.push_back(V(1,0,0,4'h2, 1,0,0,0,0,0,4'h0));
        tbl.push_back(V(1,0,0,4'h7, 2,0,0,0,0,0,4'h0));
        tbl.push_back(V(1,1,0,4'h9, 2,0,0,0,0,1,4'h7));
        tbl.push_back(V(0,1,0,4'h0, 1,0,0,0,0,1,4'h9));
        tbl.push_back(V(0,1,0,4'h0, 0,0,1,0,0,1,4'h2));
        tbl.push_back(V(1,1,0,4'h6, 1,0,0,0,1,0,4'h0));
        tbl.push_back(V(0,1,0,4'h0, 0,0,1,0,1,1,4'h6));
        tbl.push_back(V(0,0,1,4'h0, 0,0,1,0,0,0,4'h0));
        // udf set, then five pushes so a mid-operation reset has state to clear
        tbl.push_back(V(0,1,0,4'h0, 0,0,1,0,1,0,4'h0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(V(1,0,0,4'(i), 4'(i),0,0,0,1,0,4'h0));

        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_dout_valid", 32'(dout_valid), 32'(0));
        chk("rst_flags", 32'({ovf_err, udf_err}), 32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // asynchronous reset between edges with count=5 and udf set
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'(0));
        chk("async_rst_empty", 32'(empty), 32'(1));
        chk("async_rst_udf", 32'(udf_err), 32'(0));
        chk("async_rst_dout", 32'(dout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        apply(V(1,0,0,4'hB, 1,0,0,0,0,0,4'h0));
        apply(V(0,1,0,4'h0, 0,0,1,0,0,1,4'hB));

`ifdef STACK_PAIR_EN
        push2 = 1'b1; din = 4'h4; din_hi = 4'hC;
        @(posedge clk); #1;
        push2 = 1'b0;
        chk("p2_busy", 32'(busy), 32'(1));
        chk("p2_count_mid", 32'(count), 32'(1));
        @(posedge clk); #1;
        chk("p2_busy_done", 32'(busy), 32'(0));
        chk("p2_count", 32'(count), 32'(2));
        @(negedge clk);
        pop2 = 1'b1;
        sb.push_back(4'hC);
        @(posedge clk); #1;
        pop2 = 1'b0;
        chk("pop2_valid_hi", 32'(dout_valid), 32'(1));
        check_dout();
        sb.push_back(4'h4);
        @(posedge clk); #1;
        chk("pop2_valid_lo", 32'(dout_valid), 32'(1));
        check_dout();
        chk("pop2_count", 32'(count), 32'(0));
        @(negedge clk);
        for (int i = 1; i <= 7; i++)
            apply(V(1,0,0,4'(i), 4'(i),0,0,0,0,0,4'h0));
        push2 = 1'b1; din = 4'h1; din_hi = 4'h2;
        @(posedge clk); #1;
        push2 = 1'b0;
        chk("p2_ovf", 32'(ovf_err), 32'(1));
        chk("p2_ovf_count", 32'(count), 32'(7));
        chk("p2_ovf_busy", 32'(busy), 32'(0));
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Parametrised hardware stack controller for the processor datapath. It generalises the fixed 3-bit stack pointer and full/empty flags into a configurable-width, configurable-depth stack with its own storage.
- Adds registered pop data, a simultaneous push/pop (replace-top) mode, and sticky overflow/underflow error flags.
- Sits between CONTROL (push/pop strobes) and the bus (din/dout). Serves call/return and data-stack instructions.

Parameters:
- DATA_W, 4, width of one stack word
- DEPTH, 8, number of entries; must be ≥2
- PTR_W, $clog2(DEPTH), stack pointer width (derived; do not override)

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous active-low reset
- push  in  1  push din this cycle
- pop  in  1  pop top-of-stack this cycle
- din  in  DATA_W  push data
- dout  out  DATA_W  registered popped word
- dout_valid  out  1  one-cycle pulse; dout holds new popped data
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- ovf_err  out  1  sticky: push attempted while full
- udf_err  out  1  sticky: pop attempted while empty
- err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (Rst=0, asynchronous) sets:
  - sp=0, count=0, dout=0, dout_valid=0, ovf_err=0, udf_err=0
  - full=0, empty=1, FSM=IDLE
  - Storage contents are not cleared.
- sp points at the next free entry; top-of-stack is mem[sp-1].
- full and empty are combinational from count.
- Push only (not full): mem[sp]<=din; sp++, count++.
- Push only while full: write ignored, state unchanged, ovf_err<=1.
- Pop only (not empty): dout<=mem[sp-1], dout_valid<=1 on the next edge (1-cycle latency); sp--, count--.
- Pop only while empty: dout unchanged, dout_valid<=0, udf_err<=1.
- Push and pop together, not empty (full included):
  - replace-top: dout<=old mem[sp-1], dout_valid<=1, mem[sp-1]<=din.
  - sp and count unchanged; no error.
- Push and pop together while empty: treated as push only; udf_err<=1.
- dout_valid is low in every cycle without a successful pop.
- err_clr clears both sticky flags on the next edge. An error event in the same cycle as err_clr wins, so the flag stays 1.
- No wrap-around: sp saturates in 0..DEPTH-1 for the write index, count in 0..DEPTH.
- Reset asserted mid-operation (including mid pair-op) aborts immediately to the reset state.

Optional Feature:
- Macro: STACK_PAIR_EN.
- When defined, the block adds:
  - inputs push2, pop2, din_hi[DATA_W]
  - output busy
  - a 3-state FSM: IDLE, PUSH_HI, POP_LO
- push2 in IDLE with count≤DEPTH-2:
  - cycle N writes din at sp and latches din_hi; busy=1; FSM→PUSH_HI.
  - cycle N+1 writes din_hi at sp+1; FSM→IDLE.
  - count increases by 2 in total.
- pop2 in IDLE with count≥2:
  - cycle N outputs the top (high) word; FSM→POP_LO.
  - cycle N+1 outputs the low word.
  - dout_valid is high on both following edges.
- Rejected pair requests:
  - push2 with count>DEPTH-2: nothing written; ovf_err<=1.
  - pop2 with count<2: nothing popped; udf_err<=1.
- Priority and busy:
  - In IDLE, push2/pop2 take priority over push/pop.
  - While busy, all requests are ignored with no error.
  - busy resets to 0.
- When the macro is not defined, these ports do not exist and the FSM is absent.

Decomposition:
- stack_pkg holds:
  - the FSM state enum (IDLE, PUSH_HI, POP_LO)
  - default DATA_W/DEPTH localparams
  - the helper function for count-to-flag decode
- Sub-module stack_mem: DEPTH×DATA_W register array with one synchronous write port and one combinational read port. It has no reset on the array.
- stack_ctrl holds the pointers, flags, output register and FSM.

Test Plan:
- Reset then push 0x3,0xA,0x5 → count=3, empty=0; pop ×3 → dout 0x5,0xA,0x3, each one cycle after its pop with dout_valid pulses.
- Push 8 words (DEPTH=8) → full=1; 9th push 0xF → count stays 8, ovf_err=1; err_clr → ovf_err=0.
- Pop on empty → udf_err=1, dout_valid=0; err_clr with a simultaneous empty pop → udf_err remains 1.
- Stack holds 0x2,0x7; push 0x9 with pop → dout=0x7, count=2; next pop → dout=0x9.
- Rst pulsed low asynchronously between clock edges with count=5 → count=0, empty=1, flags cleared immediately.
- STACK_PAIR_EN: push2 din=0x4 din_hi=0xC → busy for 1 cycle, count=2; pop2 → dout 0xC then 0x4; push2 at count=7 → ovf_err=1, count=7.
